// File: rtl/traffic_ctrl_multi_if.sv
// traffic_ctrl_multi_if: control/lamp bundle between synchronisers, controller and lamp drivers
// Signals: tick, sensor_sync[N_DIR], wr_req[N_DIR], prog_sync (to controller);
//          lights[3*N_DIR], walk[N_DIR], wr_clear[N_DIR], phase[PW] (from controller)
// master = stimulus/synchroniser side, slave = controller side.
interface traffic_ctrl_multi_if #(
  parameter int N_DIR = 2,
  parameter int PW = N_DIR > 1 ? $clog2(N_DIR) : 1
);
  logic tick;
  logic [N_DIR-1:0] sensor_sync;
  logic [N_DIR-1:0] wr_req;
  logic prog_sync;
  logic [3*N_DIR-1:0] lights;
  logic [N_DIR-1:0] walk;
  logic [N_DIR-1:0] wr_clear;
  logic [PW-1:0] phase;
  modport master (output tick, sensor_sync, wr_req, prog_sync, input lights, walk, wr_clear, phase);
  modport slave (input tick, sensor_sync, wr_req, prog_sync, output lights, walk, wr_clear, phase);
endinterface

// File: rtl/traffic_ctrl_multi.sv
// traffic_ctrl_multi: N_DIR round-robin traffic light controller with tick timer, green extension and walk phase
// Ports: clk (rising edge), g_reset (async, active-high), bus (traffic_ctrl_multi_if.slave):
//   in  tick, sensor_sync[N_DIR], wr_req[N_DIR], prog_sync
//   out lights[3*N_DIR] ({R,Y,G} per direction), walk[N_DIR], wr_clear[N_DIR], phase
// Option macro TRAFFIC_SKIP_IDLE_EN: phase advance jumps to the next direction with sensor_sync set.
module traffic_ctrl_multi #(
  parameter int N_DIR = 2,
  parameter int CNT_W = 8,
  parameter int T_GRN = 6,
  parameter int T_EXT = 3,
  parameter int T_YEL = 2,
  parameter int T_RED = 1,
  parameter int T_WALK = 4
) (
  input logic clk,
  input logic g_reset,
  traffic_ctrl_multi_if.slave bus
);
  localparam int PW = N_DIR > 1 ? $clog2(N_DIR) : 1;
  typedef enum logic [2:0] {ALL_RED, GREEN, GREEN_EXT, YELLOW, WALK} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] timer, dur;
  logic [PW-1:0] phase, phase_adv;
  logic [N_DIR-1:0] lat, snap, clr;
  logic prog, done, walk_done, adv;
  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v >= N_DIR ? v - N_DIR : v);
  endfunction
  assign prog = bus.prog_sync;
  assign dur = state == ALL_RED ? CNT_W'(T_RED) :
               state == GREEN ? CNT_W'(T_GRN) :
               state == GREEN_EXT ? CNT_W'(T_EXT) :
               state == YELLOW ? CNT_W'(T_YEL) : CNT_W'(T_WALK);
  assign done = bus.tick && timer == dur - 1'b1;
  assign walk_done = done && !prog && state == WALK;
  assign adv = walk_done || (done && !prog && state == YELLOW && lat == '0);
  // nearest waiting direction wins: scan far-to-near so the closest overwrites
  always_comb begin
    phase_adv = wrap(int'(phase) + 1);
`ifdef TRAFFIC_SKIP_IDLE_EN
    for (int k = N_DIR - 1; k >= 1; k--)
      if (bus.sensor_sync[wrap(int'(phase) + k)]) phase_adv = wrap(int'(phase) + k);
`endif
  end
  always_ff @(posedge clk or posedge g_reset)
    if (g_reset) state <= ALL_RED;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (prog) state_n = ALL_RED;
    else if (done)
      case (state)
        ALL_RED: state_n = GREEN;
        GREEN: state_n = bus.sensor_sync[phase] ? GREEN_EXT : YELLOW;
        GREEN_EXT: state_n = YELLOW;
        YELLOW: state_n = lat != '0 ? WALK : ALL_RED;
        default: state_n = ALL_RED;
      endcase
  end
  // requests for directions being served, or arriving with their clear pulse, are absorbed
  always_ff @(posedge clk or posedge g_reset)
    if (g_reset) begin
      timer <= '0;
      phase <= '0;
      lat <= '0;
      snap <= '0;
      clr <= '0;
    end else begin
      timer <= (prog || done) ? '0 : timer + CNT_W'(bus.tick);
      phase <= prog ? '0 : adv ? phase_adv : phase;
      lat <= (lat & ~(walk_done ? snap : '0)) | (bus.wr_req & ~clr & ~(state == WALK ? snap : '0));
      snap <= (prog || walk_done) ? '0 : (state == YELLOW && state_n == WALK) ? lat : snap;
      clr <= walk_done ? snap : '0;
    end
  always_comb begin
    bus.lights = '0;
    for (int i = 0; i < N_DIR; i++)
      bus.lights[3*i +: 3] = PW'(i) != phase ? 3'b100 :
                             (state == GREEN || state == GREEN_EXT) ? 3'b001 :
                             state == YELLOW ? 3'b010 : 3'b100;
    bus.walk = snap;
    bus.wr_clear = clr;
    bus.phase = phase;
  end
endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// tb_traffic_ctrl_multi: directed scenarios plus randomized run against a countdown reference model
module tb_traffic_ctrl_multi;
  localparam int N = 2;
  localparam int PW = 1;
  localparam int T_GRN = 6, T_EXT = 3, T_YEL = 2, T_RED = 1, T_WALK = 4;
  localparam int K_AR = 0, K_G = 1, K_EXT = 2, K_Y = 3, K_WALK = 4;
  localparam logic [3*N-1:0] ALL_R = {N{3'b100}};
  typedef struct packed {
    int k;
    int left;
    int ph;
    logic [N-1:0] lat;
    logic [N-1:0] snap;
    logic [N-1:0] clr;
  } mdl_t;
  logic clk = 1'b0;
  logic g_reset = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  mdl_t m;
  traffic_ctrl_multi_if #(.N_DIR(N)) bus();
  traffic_ctrl_multi #(.N_DIR(N)) dut (.clk(clk), .g_reset(g_reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic int nextdir(input int ph, input logic [N-1:0] s);
    int r;
    r = (ph + 1) % N;
`ifdef TRAFFIC_SKIP_IDLE_EN
    for (int k = 1; k < N; k++)
      if (s[(ph + k) % N]) begin
        r = (ph + k) % N;
        break;
      end
`endif
    return r;
  endfunction
  function automatic mdl_t mreset();
    mdl_t r;
    r.k = K_AR;
    r.left = T_RED;
    r.ph = 0;
    r.lat = '0;
    r.snap = '0;
    r.clr = '0;
    return r;
  endfunction
  function automatic mdl_t step(input mdl_t c, input logic t, input logic [N-1:0] s, input logic [N-1:0] rq, input logic p);
    mdl_t n;
    logic [N-1:0] nreq;
    n = c;
    nreq = rq & ~c.clr & ~(c.k == K_WALK ? c.snap : '0);
    n.clr = '0;
    if (p) begin
      n.k = K_AR; n.left = T_RED; n.ph = 0; n.snap = '0;
    end else if (t && c.left == 1) begin
      case (c.k)
        K_AR: begin n.k = K_G; n.left = T_GRN; end
        K_G: if (s[c.ph]) begin n.k = K_EXT; n.left = T_EXT; end
             else begin n.k = K_Y; n.left = T_YEL; end
        K_EXT: begin n.k = K_Y; n.left = T_YEL; end
        K_Y: if (c.lat != '0) begin n.k = K_WALK; n.left = T_WALK; n.snap = c.lat; end
             else begin n.k = K_AR; n.left = T_RED; n.ph = nextdir(c.ph, s); end
        default: begin
          n.clr = c.snap; n.lat = c.lat & ~c.snap; n.snap = '0;
          n.k = K_AR; n.left = T_RED; n.ph = nextdir(c.ph, s);
        end
      endcase
    end else if (t) n.left = c.left - 1;
    n.lat = n.lat | nreq;
    return n;
  endfunction
  function automatic logic [3*N-1:0] mlights(input mdl_t c);
    logic [3*N-1:0] l;
    for (int i = 0; i < N; i++)
      l[3*i +: 3] = i != c.ph ? 3'b100 : (c.k == K_G || c.k == K_EXT) ? 3'b001 : c.k == K_Y ? 3'b010 : 3'b100;
    return l;
  endfunction
  always @(posedge clk or posedge g_reset)
    if (g_reset) m <= mreset();
    else m <= step(m, bus.tick, bus.sensor_sync, bus.wr_req, bus.prog_sync);
  task automatic do_reset();
    g_reset = 1'b1;
    bus.tick = 1'b1; bus.sensor_sync = '0; bus.wr_req = '0; bus.prog_sync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    g_reset = 1'b0;
  endtask
  task automatic test_reset();
    g_reset = 1'b1;
    bus.tick = 1'b1; bus.sensor_sync = '1; bus.wr_req = '1; bus.prog_sync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests += 4;
    if (bus.lights !== ALL_R) begin n_fail++; $display("FAIL reset_lights got %b want %b", bus.lights, ALL_R); end
    if (bus.walk !== '0) begin n_fail++; $display("FAIL reset_walk got %b want 0", bus.walk); end
    if (bus.wr_clear !== '0) begin n_fail++; $display("FAIL reset_wr_clear got %b want 0", bus.wr_clear); end
    if (bus.phase !== '0) begin n_fail++; $display("FAIL reset_phase got %0d want 0", bus.phase); end
    bus.wr_req = '0; bus.sensor_sync = '0;
    g_reset = 1'b0;
  endtask
  task automatic test_sequence();
    logic [3*N-1:0] el;
    logic [PW-1:0] ep;
    do_reset();
    for (int c = 0; c < 19; c++) begin
      el = (c == 0 || c == 9 || c == 18) ? ALL_R : c <= 6 ? 6'b100001 : c <= 8 ? 6'b100010 : c <= 15 ? 6'b001100 : 6'b010100;
      ep = PW'(c >= 9 && c <= 17);
      n_tests += 2;
      if (bus.lights !== el) begin n_fail++; $display("FAIL seq_lights c=%0d got %b want %b", c, bus.lights, el); end
      if (bus.phase !== ep) begin n_fail++; $display("FAIL seq_phase c=%0d got %0d want %0d", c, bus.phase, ep); end
      @(negedge clk);
    end
  endtask
  task automatic test_extension();
    int runs[9];
    int r;
    logic [3*N-1:0] prev;
    logic [3*N-1:0] after_g0;
    do_reset();
    bus.sensor_sync = 2'b01;
    runs = '{default: 0};
    r = 0;
    after_g0 = '0;
    prev = bus.lights;
    for (int c = 0; c < 100 && r < 8; c++) begin
      @(negedge clk);
      runs[r]++;
      if (bus.lights !== prev) begin
        r++;
        prev = bus.lights;
        if (r == 2) after_g0 = bus.lights;
      end
    end
    n_tests += 4;
    if (runs[1] != 9) begin n_fail++; $display("FAIL ext_g0_len got %0d want 9", runs[1]); end
    if (after_g0 !== 6'b100010) begin n_fail++; $display("FAIL ext_then_yellow got %b want 100010", after_g0); end
    if (runs[4] != 6) begin n_fail++; $display("FAIL ext_g1_len got %0d want 6", runs[4]); end
    if (runs[7] != 9) begin n_fail++; $display("FAIL ext_second_g0_len got %0d want 9", runs[7]); end
    bus.sensor_sync = '0;
  endtask
  task automatic test_walk();
    logic [3*N-1:0] el;
    logic [N-1:0] ew, ec;
    do_reset();
    for (int c = 0; c < 28; c++) begin
      el = c == 0 ? ALL_R : c <= 6 ? 6'b100001 : c <= 8 ? 6'b100010 : c <= 13 ? ALL_R :
           c <= 19 ? 6'b001100 : c <= 21 ? 6'b010100 : c <= 26 ? ALL_R : 6'b100001;
      ew = (c >= 9 && c <= 12) ? 2'b10 : (c >= 22 && c <= 25) ? 2'b01 : 2'b00;
      ec = c == 13 ? 2'b10 : c == 26 ? 2'b01 : 2'b00;
      n_tests += 3;
      if (bus.lights !== el) begin n_fail++; $display("FAIL walk_lights c=%0d got %b want %b", c, bus.lights, el); end
      if (bus.walk !== ew) begin n_fail++; $display("FAIL walk_lamp c=%0d got %b want %b", c, bus.walk, ew); end
      if (bus.wr_clear !== ec) begin n_fail++; $display("FAIL walk_clear c=%0d got %b want %b", c, bus.wr_clear, ec); end
      bus.wr_req = c == 1 ? 2'b10 : c == 10 ? 2'b01 : 2'b00;
      @(negedge clk);
    end
    bus.wr_req = '0;
  endtask
  task automatic test_prog();
    do_reset();
    for (int c = 0; c < 27; c++) begin
      if (c == 17) begin
        n_tests += 3;
        if (bus.lights !== ALL_R) begin n_fail++; $display("FAIL prog_lights got %b want %b", bus.lights, ALL_R); end
        if (bus.phase !== '0) begin n_fail++; $display("FAIL prog_phase got %0d want 0", bus.phase); end
        if (bus.wr_clear !== '0) begin n_fail++; $display("FAIL prog_no_clear got %b want 0", bus.wr_clear); end
      end
      if (c == 18) begin
        n_tests++;
        if (bus.lights !== 6'b100001) begin n_fail++; $display("FAIL prog_restart_g0 got %b want 100001", bus.lights); end
      end
      if (c == 26) begin
        n_tests += 2;
        if (bus.walk !== 2'b01) begin n_fail++; $display("FAIL prog_latch_kept got %b want 01", bus.walk); end
        if (bus.lights !== ALL_R) begin n_fail++; $display("FAIL prog_walk_red got %b want %b", bus.lights, ALL_R); end
      end
      bus.prog_sync = c == 16;
      bus.wr_req = c == 16 ? 2'b01 : 2'b00;
      @(negedge clk);
    end
    bus.prog_sync = 1'b0;
    bus.wr_req = '0;
  endtask
  task automatic test_async_reset();
    do_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.lights !== 6'b100001) begin n_fail++; $display("FAIL areset_pre got %b want 100001", bus.lights); end
    @(posedge clk);
    #2 g_reset = 1'b1;
    #1;
    n_tests += 2;
    if (bus.lights !== ALL_R) begin n_fail++; $display("FAIL areset_lights got %b want %b", bus.lights, ALL_R); end
    if (bus.phase !== '0) begin n_fail++; $display("FAIL areset_phase got %0d want 0", bus.phase); end
    @(negedge clk);
    g_reset = 1'b0;
  endtask
  task automatic test_tick_div();
    int runs[6];
    int r;
    logic [3*N-1:0] prev;
    logic [PW-1:0] ph;
    do_reset();
    runs = '{default: 0};
    r = 0;
    prev = bus.lights;
    for (int c = 0; c < 150 && r < 5; c++) begin
      bus.tick = (c % 3) == 2;
      @(negedge clk);
      runs[r]++;
      if (bus.lights !== prev) begin
        r++;
        prev = bus.lights;
      end
    end
    n_tests += 5;
    if (runs[0] != 3) begin n_fail++; $display("FAIL tick_ar got %0d want 3", runs[0]); end
    if (runs[1] != 18) begin n_fail++; $display("FAIL tick_g0 got %0d want 18", runs[1]); end
    if (runs[2] != 6) begin n_fail++; $display("FAIL tick_y0 got %0d want 6", runs[2]); end
    if (runs[3] != 3) begin n_fail++; $display("FAIL tick_ar2 got %0d want 3", runs[3]); end
    if (runs[4] != 18) begin n_fail++; $display("FAIL tick_g1 got %0d want 18", runs[4]); end
    bus.tick = 1'b0;
    prev = bus.lights;
    ph = bus.phase;
    repeat (20) @(negedge clk);
    n_tests++;
    if (bus.lights !== prev || bus.phase !== ph) begin
      n_fail++; $display("FAIL tick_freeze got %b/%0d want %b/%0d", bus.lights, bus.phase, prev, ph);
    end
    bus.tick = 1'b1;
  endtask
  task automatic test_random();
    int nonr;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      n_tests++;
      if (bus.lights !== mlights(m) || bus.walk !== m.snap || bus.wr_clear !== m.clr || bus.phase !== PW'(m.ph)) begin
        n_fail++;
        if (n_fail < 20)
          $display("FAIL random c=%0d lights %b/%b walk %b/%b clr %b/%b phase %0d/%0d", c,
                   bus.lights, mlights(m), bus.walk, m.snap, bus.wr_clear, m.clr, bus.phase, m.ph);
      end
      nonr = 0;
      for (int i = 0; i < N; i++) nonr += (bus.lights[3*i +: 3] != 3'b100) ? 1 : 0;
      n_tests++;
      if (nonr > 1 || (bus.walk != '0 && bus.lights !== ALL_R)) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL invariant c=%0d lights %b walk %b", c, bus.lights, bus.walk);
      end
      bus.tick = $urandom_range(0, 9) < 7;
      bus.sensor_sync = N'($urandom);
      bus.wr_req = $urandom_range(0, 7) == 0 ? N'($urandom) : '0;
      bus.prog_sync = $urandom_range(0, 99) == 0;
      @(negedge clk);
    end
    bus.prog_sync = 1'b0;
    bus.wr_req = '0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
  initial begin
    bus.tick = 1'b0; bus.sensor_sync = '0; bus.wr_req = '0; bus.prog_sync = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequence();
    test_extension();
    test_walk();
    test_prog();
    test_async_reset();
    test_tick_div();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
